// File: rtl/riscv_str_ops_seq.sv
// Memory-to-memory sequencer for the string-ops unit: walks a string word by word,
// pushes each word through the external datapath and writes the result back in place.
module riscv_str_ops_seq #(
   parameter int unsigned STR_OP_WIDTH = 2,
   parameter int unsigned LEN_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   input  logic [STR_OP_WIDTH-1:0] operator_i,
   input  logic [31:0]             addr_i,
   input  logic [LEN_WIDTH-1:0]    len_i,
   output logic                    ready_o,
   output logic                    done_o,
   output logic [LEN_WIDTH-1:0]    count_o,
   output logic                    data_req_o,
   input  logic                    data_gnt_i,
   input  logic                    data_rvalid_i,
   output logic [31:0]             data_addr_o,
   output logic                    data_we_o,
   output logic [3:0]              data_be_o,
   output logic [31:0]             data_wdata_o,
   input  logic [31:0]             data_rdata_i,
   output logic                    str_enable_o,
   output logic [STR_OP_WIDTH-1:0] str_operator_o,
   output logic [31:0]             str_operand_o,
   input  logic [31:0]             str_result_i
);

   typedef enum logic [2:0] {
      StIdle, StLoadReq, StLoadWait, StStoreReq, StStoreWait, StDone
   } state_e;

   state_e                  state_q, state_d;
   logic [31:0]             addr_q, addr_d;
   logic [LEN_WIDTH-1:0]    rem_q, rem_d;
   logic [LEN_WIDTH-1:0]    count_q, count_d;
   logic [STR_OP_WIDTH-1:0] op_q, op_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              mask_q, mask_d;
   logic                    nul_q, nul_d;

   logic [2:0] n_valid;
   logic [3:0] mask_c;
   logic       nul_c;
   logic       run;
   logic [2:0] pop;

   // A byte survives only if it is inside the length and no NUL precedes or is it.
   always_comb begin
      n_valid = (rem_q < LEN_WIDTH'(4)) ? rem_q[2:0] : 3'd4;
      run     = 1'b1;
      nul_c   = 1'b0;
      mask_c  = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         if ((3'(k) < n_valid) && (data_rdata_i[8*k +: 8] == 8'h00)) begin
            nul_c = 1'b1;
            run   = 1'b0;
         end
         mask_c[k] = (3'(k) < n_valid) && run;
      end
      pop = 3'(mask_q[0]) + 3'(mask_q[1]) + 3'(mask_q[2]) + 3'(mask_q[3]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         rem_q   <= '0;
         count_q <= '0;
         op_q    <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         nul_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         count_q <= count_d;
         op_q    <= op_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         nul_q   <= nul_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      count_d = count_q;
      op_d    = op_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      nul_d   = nul_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               addr_d  = {addr_i[31:2], 2'b00};
               rem_d   = len_i;
               count_d = '0;
               op_d    = operator_i;
               state_d = (len_i == '0) ? StDone : StLoadReq;
            end
         end
         StLoadReq: if (data_gnt_i) state_d = StLoadWait;
         StLoadWait: begin
            if (data_rvalid_i) begin
               wdata_d = str_result_i;
               mask_d  = mask_c;
               nul_d   = nul_c;
               state_d = (mask_c == 4'b0000) ? StDone : StStoreReq;
            end
         end
         StStoreReq: if (data_gnt_i) state_d = StStoreWait;
         StStoreWait: begin
            if (data_rvalid_i) begin
               count_d = count_q + LEN_WIDTH'(pop);
               if (nul_q || (rem_q <= LEN_WIDTH'(4))) begin
                  state_d = StDone;
               end else begin
                  addr_d  = addr_q + 32'd4;
                  rem_d   = rem_q - LEN_WIDTH'(4);
                  state_d = StLoadReq;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ready_o        = (state_q == StIdle);
      done_o         = (state_q == StDone);
      count_o        = count_q;
      data_req_o     = 1'b0;
      data_addr_o    = 32'h0;
      data_we_o      = 1'b0;
      data_be_o      = 4'b0000;
      data_wdata_o   = 32'h0;
      str_enable_o   = (state_q == StLoadWait) && data_rvalid_i;
      str_operator_o = op_q;
      str_operand_o  = data_rdata_i;
      if (state_q == StLoadReq) begin
         data_req_o  = 1'b1;
         data_addr_o = addr_q;
         data_be_o   = 4'b1111;
      end else if (state_q == StStoreReq) begin
         data_req_o   = 1'b1;
         data_addr_o  = addr_q;
         data_we_o    = 1'b1;
         data_be_o    = mask_q;
         data_wdata_o = wdata_q;
      end
   end

endmodule

// File: tb/tb_riscv_str_ops_seq.sv
// Directed bench for riscv_str_ops_seq with a delay-configurable memory responder
// and an uppercase string-ops model.
module tb_riscv_str_ops_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] addr = '0;
   logic [15:0] len = '0;
   logic        ready, done;
   logic [15:0] count;
   logic        req, we;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] maddr, wdata;
   logic [31:0] rdata = '0;
   logic [3:0]  be;
   logic        str_en;
   logic [1:0]  str_op;
   logic [31:0] operand, result;

   always #5 clk = ~clk;

   riscv_str_ops_seq #(.STR_OP_WIDTH(2), .LEN_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .operator_i(op), .addr_i(addr), .len_i(len),
      .ready_o(ready), .done_o(done), .count_o(count), .data_req_o(req), .data_gnt_i(gnt),
      .data_rvalid_i(rvalid), .data_addr_o(maddr), .data_we_o(we), .data_be_o(be),
      .data_wdata_o(wdata), .data_rdata_i(rdata), .str_enable_o(str_en),
      .str_operator_o(str_op), .str_operand_o(operand), .str_result_i(result)
   );

   // Operator 1 = uppercase ASCII letters, anything else passes through.
   always_comb begin
      result = operand;
      if (str_op == 2'd1) begin
         for (int k = 0; k < 4; k++) begin
            if (operand[8*k +: 8] >= 8'h61 && operand[8*k +: 8] <= 8'h7a)
               result[8*k +: 8] = operand[8*k +: 8] - 8'h20;
         end
      end
   end

   logic [31:0] mem [0:255];
   int n_tests = 0, n_fail = 0;
   int gnt_dly = 0, rv_dly = 0;
   int n_st, n_loads, n_en, n_done, unstable;
   logic [31:0] st_addr [0:7];
   logic [31:0] st_data [0:7];
   logic [3:0]  st_be [0:7];
   int g_cnt = 0, rv_cnt = 0;
   logic pend = 1'b0, pend_we = 1'b0;
   logic [31:0] pend_a = '0;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;
   int dc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic clear_logs();
      n_st = 0; n_loads = 0; n_en = 0; n_done = 0; unstable = 0;
      for (int i = 0; i < 8; i++) begin
         st_addr[i] = '0; st_data[i] = '0; st_be[i] = '0;
      end
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [15:0] l,
                      input int poke, output int done_cyc);
      clear_logs();
      @(negedge clk);
      start = 1'b1; op = o; addr = a; len = l;
      @(posedge clk);
      #1 start = 1'b0;
      done_cyc = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == poke) begin
            start = 1'b1; op = 2'd0; addr = 32'h300; len = 16'd1;
         end
         if (c == poke + 1) start = 1'b0;
         #2;
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      @(negedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      clear_logs();
      fork
         forever begin
            @(negedge clk);
            gnt = 1'b0;
            rvalid = 1'b0;
            if (pend) begin
               if (rv_cnt > 0) rv_cnt--;
               else begin
                  rvalid = 1'b1;
                  rdata  = pend_we ? 32'h0 : mem[pend_a[9:2]];
                  pend   = 1'b0;
               end
            end else if (req) begin
               if (g_cnt == 0) begin
                  cap_addr = maddr; cap_we = we; cap_be = be; cap_wdata = wdata;
               end else if (maddr !== cap_addr || we !== cap_we || be !== cap_be ||
                            wdata !== cap_wdata) begin
                  unstable++;
               end
               if (g_cnt < gnt_dly) g_cnt++;
               else begin
                  gnt = 1'b1; g_cnt = 0; pend = 1'b1; pend_we = we; pend_a = maddr;
                  rv_cnt = rv_dly;
                  if (we) begin
                     if (n_st < 8) begin
                        st_addr[n_st] = maddr; st_data[n_st] = wdata; st_be[n_st] = be;
                     end
                     n_st++;
                     for (int k = 0; k < 4; k++)
                        if (be[k]) mem[maddr[9:2]][8*k +: 8] = wdata[8*k +: 8];
                  end else n_loads++;
               end
            end
            #1;
            if (str_en) n_en++;
            if (done) n_done++;
         end
      join_none

      #12;
      check("rst_ready", 32'(ready), 32'h1);
      check("rst_done", 32'(done), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_req", 32'(req), 32'h0);
      check("rst_en", 32'(str_en), 32'h0);
      check("rst_op", 32'(str_op), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // "hello wo", len 8, zero-wait
      mem[8'h40] = 32'h6c6c6568; mem[8'h41] = 32'h6f77206f;
      run(2'd1, 32'h100, 16'd8, 0, dc);
      check("hello_done_cyc", 32'(dc), 32'd9);
      check("hello_count", 32'(count), 32'd8);
      check("hello_nst", 32'(n_st), 32'd2);
      check("hello_a0", st_addr[0], 32'h100);
      check("hello_be0", 32'(st_be[0]), 32'hf);
      check("hello_d0", st_data[0], 32'h4c4c4548);
      check("hello_a1", st_addr[1], 32'h104);
      check("hello_be1", 32'(st_be[1]), 32'hf);
      check("hello_d1", st_data[1], 32'h4f57204f);
      check("hello_loads", 32'(n_loads), 32'd2);
      check("hello_en", 32'(n_en), 32'd2);
      check("hello_ndone", 32'(n_done), 32'd1);
      check("hello_ready", 32'(ready), 32'h1);
      check("hello_op_held", 32'(str_op), 32'd1);

      // len 6, same data
      mem[8'h40] = 32'h6c6c6568; mem[8'h41] = 32'h6f77206f;
      run(2'd1, 32'h100, 16'd6, 0, dc);
      check("len6_done_cyc", 32'(dc), 32'd9);
      check("len6_count", 32'(count), 32'd6);
      check("len6_be1", 32'(st_be[1]), 32'h3);
      check("len6_mem1", mem[8'h41], 32'h6f77204f);
      check("len6_ndone", 32'(n_done), 32'd1);

      // NUL inside first word
      mem[8'h80] = 32'h00006968; mem[8'h81] = 32'h61616161;
      run(2'd1, 32'h202, 16'd16, 0, dc);
      check("hi_done_cyc", 32'(dc), 32'd5);
      check("hi_nst", 32'(n_st), 32'd1);
      check("hi_be", 32'(st_be[0]), 32'h3);
      check("hi_lo", {16'h0, st_data[0][15:0]}, 32'h4949 - 32'h1);
      check("hi_addr", st_addr[0], 32'h200);
      check("hi_loads", 32'(n_loads), 32'd1);
      check("hi_count", 32'(count), 32'd2);

      // leading NUL: store skipped
      mem[8'hc0] = 32'h41424300;
      run(2'd1, 32'h300, 16'd4, 0, dc);
      check("nul0_done_cyc", 32'(dc), 32'd3);
      check("nul0_nst", 32'(n_st), 32'd0);
      check("nul0_count", 32'(count), 32'd0);

      // zero length
      run(2'd1, 32'h100, 16'd0, 0, dc);
      check("len0_done_cyc", 32'(dc), 32'd1);
      check("len0_loads", 32'(n_loads), 32'd0);

      // delayed memory plus a start pulse while busy
      mem[8'h40] = 32'h6c6c6568; mem[8'h41] = 32'h6f77206f;
      gnt_dly = 3; rv_dly = 2;
      run(2'd1, 32'h100, 16'd8, 3, dc);
      check("dly_done_cyc", 32'(dc), 32'd29);
      check("dly_stable", 32'(unstable), 32'd0);
      check("dly_en", 32'(n_en), 32'd2);
      check("dly_count", 32'(count), 32'd8);
      check("dly_d1", st_data[1], 32'h4f57204f);
      check("dly_a1", st_addr[1], 32'h104);
      check("dly_op_held", 32'(str_op), 32'd1);

      // reset while waiting for load data
      gnt_dly = 0; rv_dly = 5;
      clear_logs();
      @(negedge clk);
      start = 1'b1; op = 2'd1; addr = 32'h100; len = 16'd8;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(ready), 32'h1);
      check("mid_rst_req", 32'(req), 32'h0);
      check("mid_rst_op", 32'(str_op), 32'h0);
      check("mid_rst_count", 32'(count), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      #2;
      check("post_rst_ready", 32'(ready), 32'h1);
      check("post_rst_nst", 32'(n_st), 32'd0);
      check("post_rst_en", 32'(n_en), 32'd0);
      rv_dly = 0;
      mem[8'h80] = 32'h00006968;
      run(2'd1, 32'h200, 16'd16, 0, dc);
      check("post_rst_done_cyc", 32'(dc), 32'd5);
      check("post_rst_count", 32'(count), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
